// File: rtl/pulse_divider.sv
// Programmable clock-enable generator: one slow_pulse every P cycles, with a
// run-time loadable period and a halt / single-step mode for debug.
module pulse_divider #(
  parameter int CNT_WIDTH = 4,
  parameter int RESET_DIV = 3
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [CNT_WIDTH-1:0] div_in,
  input  logic                 div_load,
  input  logic                 halt,
  input  logic                 step,
  output logic                 slow_pulse,
  output logic                 end_pulse,
  output logic [CNT_WIDTH-1:0] phase,
  output logic [CNT_WIDTH-1:0] div_active,
  output logic                 halted
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RESET_P = CNT_WIDTH'(RESET_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] p_q, p_d;
  logic [CNT_WIDTH-1:0] q_q, q_d;
  logic                 pend_q, pend_d;

  logic                 running;
  logic                 last;
  logic                 boundary;
  logic [CNT_WIDTH-1:0] div_clamped;

  assign running     = (state_q != S_HALTED);
  assign last        = (cnt_q == p_q - ONE);
  assign boundary    = running && last;
  // A zero period is meaningless; treat it as divide-by-1.
  assign div_clamped = (div_in == '0) ? ONE : div_in;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    pend_d  = pend_q;

    unique case (state_q)
      S_RUN: begin
        if (boundary && halt) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (!halt)     state_d = S_RUN;
        else if (step) state_d = S_STEP;
      end
      S_STEP: begin
        if (boundary) state_d = halt ? S_HALTED : S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    if (!running || boundary) cnt_d = '0;
    else                      cnt_d = cnt_q + ONE;

    // A load landing on a boundary goes straight into the next period;
    // otherwise it waits in Q until the next boundary or halted cycle.
    if (boundary && div_load) begin
      p_d    = div_clamped;
      pend_d = 1'b0;
    end else begin
      if (pend_q && (boundary || !running)) begin
        p_d    = q_q;
        pend_d = 1'b0;
      end
      if (div_load) begin
        q_d    = div_clamped;
        pend_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      p_q     <= RESET_P;
      q_q     <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      pend_q  <= pend_d;
    end
  end

  assign slow_pulse = running && (cnt_q == '0);
  assign end_pulse  = boundary;
  assign phase      = cnt_q;
  assign div_active = p_q;
  assign halted     = !running;

endmodule

// File: tb/tb_pulse_divider.sv
// Scoreboard bench for pulse_divider: a period-level reference model pushes
// the expected outputs per cycle, and a monitor pops and compares them.
module tb_pulse_divider;

  localparam int W  = 4;
  localparam int RD = 3;

  logic         clk;
  logic         nrst;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         halt;
  logic         step;
  logic         slow_pulse;
  logic         end_pulse;
  logic [W-1:0] phase;
  logic [W-1:0] div_active;
  logic         halted;

  pulse_divider #(.CNT_WIDTH(W), .RESET_DIV(RD)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .div_in     (div_in),
    .div_load   (div_load),
    .halt       (halt),
    .step       (step),
    .slow_pulse (slow_pulse),
    .end_pulse  (end_pulse),
    .phase      (phase),
    .div_active (div_active),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic         slow;
    logic         fin;
    logic [W-1:0] ph;
    logic [W-1:0] dv;
    logic         hl;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the block is either frozen or counting through a period
  // of length m_p; stepping and free running differ only in what halt does at
  // the period end, which is the same decision in both cases.
  bit m_frozen;
  int m_pos;
  int m_p;
  int m_q;
  bit m_pend;

  function automatic int clamp(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_frozen = 1'b0;
    m_pos    = 0;
    m_p      = RD;
    m_q      = 0;
    m_pend   = 1'b0;
  endtask

  task automatic model_clock(input bit ld, input int din, input bit h, input bit st);
    if (m_frozen) begin
      m_pos = 0;
      if (m_pend) begin
        m_p    = m_q;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_q    = clamp(din);
        m_pend = 1'b1;
      end
      if (!h || st) m_frozen = 1'b0;
    end else if (m_pos == m_p - 1) begin
      m_pos = 0;
      if (ld) begin
        m_p    = clamp(din);
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_p    = m_q;
        m_pend = 1'b0;
      end
      m_frozen = h;
    end else begin
      m_pos = m_pos + 1;
      if (ld) begin
        m_q    = clamp(din);
        m_pend = 1'b1;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.slow = !m_frozen && (m_pos == 0);
    e.fin  = !m_frozen && (m_pos == m_p - 1);
    e.ph   = W'(m_pos);
    e.dv   = W'(m_p);
    e.hl   = m_frozen;
    return e;
  endfunction

  // Monitor: outputs are compared mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("slow_pulse", 8'(slow_pulse), 8'(e.slow));
        check("end_pulse",  8'(end_pulse),  8'(e.fin));
        check("phase",      8'(phase),      8'(e.ph));
        check("div_active", 8'(div_active), 8'(e.dv));
        check("halted",     8'(halted),     8'(e.hl));
      end
    end
  end

  task automatic cyc(input bit ld, input int din, input bit h, input bit st);
    div_load = ld;
    div_in   = W'(din);
    halt     = h;
    step     = st;
    @(posedge clk);
    #1;
    model_clock(ld, din, h, st);
    sb.push_back(model_out());
    div_load = 1'b0;
    step     = 1'b0;
  endtask

  task automatic do_reset(input int n, input bit mid_run);
    if (mid_run) begin
      @(negedge clk);
      #1;
    end
    nrst     = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    halt     = 1'b0;
    step     = 1'b0;
    model_reset();
    if (mid_run) begin
      #1;
      check("rst_slow_pulse", 8'(slow_pulse), 8'(1));
      check("rst_end_pulse",  8'(end_pulse),  8'(RD == 1));
      check("rst_phase",      8'(phase),      8'(0));
      check("rst_div_active", 8'(div_active), 8'(RD));
      check("rst_halted",     8'(halted),     8'(0));
    end
    repeat (n) begin
      @(posedge clk);
      #1;
      sb.push_back(model_out());
    end
    nrst = 1'b1;
  endtask

  task automatic idle_until(input int k, input bit h);
    for (int i = 0; i < 40 && m_pos != k; i++) cyc(0, 0, h, 0);
    n_checks++;
    if (m_pos != k) begin
      n_fail++;
      $display("FAIL align: phase %0d never reached", k);
    end
  endtask

  initial begin
    bit h_lvl;
    nrst     = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    halt     = 1'b0;
    step     = 1'b0;
    model_reset();

    do_reset(2, 1'b0);
    repeat (9) cyc(0, 0, 0, 0);

    // Two loads in one period: the later one wins at the boundary.
    idle_until(1, 0);
    cyc(1, 5, 0, 0);
    cyc(1, 2, 0, 0);
    repeat (8) cyc(0, 0, 0, 0);
    cyc(1, 5, 0, 0);
    repeat (12) cyc(0, 0, 0, 0);

    // Zero divisor clamps to 1: both pulses every cycle.
    cyc(1, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);

    // Halt requested at phase 0 of a P=4 period, then released.
    cyc(1, 4, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    idle_until(0, 0);
    repeat (8) cyc(0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0);

    // Single step while halted, then a step with halt low.
    cyc(1, 3, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    repeat (6) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    repeat (6) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0);

    // Reset mid-period with a load pending: the load must vanish.
    idle_until(0, 0);
    cyc(1, 7, 0, 0);
    cyc(0, 0, 0, 0);
    do_reset(2, 1'b1);
    repeat (10) cyc(0, 0, 0, 0);

    // Randomized traffic.
    h_lvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) h_lvl = !h_lvl;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1, 1'b1);
        h_lvl = 1'b0;
      end else begin
        cyc(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
            h_lvl, ($urandom_range(0, 4) == 0));
      end
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_divider.md
# pulse_divider

Programmable clock-enable generator; the parametrised successor of the fixed divide-by-3 enable pulse in the control logic. It produces a one-cycle `slow_pulse` once every P clock cycles and an `end_pulse` on the last cycle of each period. P is loadable at run time and takes effect only at a period boundary. A halt/single-step mode lets the control unit freeze the datapath enables between periods for debug.

## Interface
- `CNT_WIDTH`, default 4: width of the period counter and divisor; legal P is 1..2^CNT_WIDTH−1.
- `RESET_DIV`, default 3: period loaded at reset; must be 1..2^CNT_WIDTH−1.

Ports:
- `clk`  in  1: the single clock.
- `nrst`  in  1: asynchronous reset, active low.
- `div_in`  in  CNT_WIDTH: new period value.
- `div_load`  in  1: capture `div_in` into the pending register this cycle.
- `halt`  in  1: level; requests a stop at the next period boundary.
- `step`  in  1: single-cycle request; runs exactly one period while halted.
- `slow_pulse`  out  1: high in the first cycle of each running period.
- `end_pulse`  out  1: high in the last cycle of each running period.
- `phase`  out  CNT_WIDTH: current counter value, 0..P−1.
- `div_active`  out  CNT_WIDTH: period currently in force.
- `halted`  out  1: high while in HALTED.

## Operation
- The block holds these registers: state (RUN, HALTED, STEP), counter `cnt`, active period P, pending period Q, and a `pend` flag.
- `slow_pulse` = (`cnt`==0) && state≠HALTED. It is combinational from registers.
- `end_pulse` = (`cnt`==P−1) && state≠HALTED. When P==1, both pulses are high every running cycle.
- `phase`=`cnt`, `div_active`=P, `halted`=(state==HALTED).
- A boundary is any running cycle with `cnt`==P−1. At a boundary, `cnt` is set to 0. In every other running cycle, `cnt` increments by 1.

State transitions (evaluated each clock):
- RUN: at a boundary, go to HALTED if `halt`==1; otherwise stay in RUN.
- HALTED: `cnt` is held at 0. Go to RUN if `halt`==0. Otherwise go to STEP if `step`==1. Otherwise stay. When `halt` is low, `step` is ignored.
- STEP: counts exactly like RUN. At its boundary, go to HALTED if `halt`==1, otherwise go to RUN.
- `halt` asserted mid-period never truncates the period. The current period always completes.
- `step` outside HALTED is ignored. `step` is not queued.

Divisor load:
- `div_load`=1 sets Q←`div_in` and `pend`←1. A later load before application overwrites Q; the last value wins.
- A `div_in` of 0 is clamped to 1.
- Q is applied (P←Q, `pend`←0) at the next boundary, or on the next clock edge while in HALTED.
- If `div_load` coincides with a boundary, the new value applies to the period that starts next.
- P never changes mid-period.

## Timing
- Reset (`nrst`=0) asynchronously sets state=RUN, `cnt`=0, P=`RESET_DIV`, Q=0, `pend`=0.
- Outputs during and immediately after reset: `slow_pulse`=1, `end_pulse`=(`RESET_DIV`==1), `phase`=0, `div_active`=`RESET_DIV`, `halted`=0.
- The first `slow_pulse` is the cycle reset releases. Subsequent pulses come exactly every P cycles.
- Latency to HALTED: `halted` rises the cycle after the boundary at which `halt` was sampled high.
- Leaving halt: when `halt` falls while HALTED, `slow_pulse` goes high 1 cycle later, with `cnt`=0.
- Step: `step` sampled in HALTED gives `slow_pulse` on the next cycle. Exactly P running cycles follow, with one `slow_pulse` and one `end_pulse`.
- A reset asserted mid-period or mid-step aborts immediately. Pending loads are discarded.
- All inputs are synchronous to `clk`. There are no combinational paths from inputs to outputs.

## Test plan
- Reset release with defaults (P=3): `slow_pulse` high in cycles 0, 3, 6; `end_pulse` high in cycles 2, 5, 8; `phase` sequence 0,1,2,0.
- Load `div_in`=5 at `phase`=1 of a P=3 period: `div_active` stays 3 until the boundary, then 5. The next pulses are 5 cycles apart. A second load of 2 before the boundary wins.
- Load `div_in`=0: `div_active` becomes 1. `slow_pulse` and `end_pulse` are high every cycle.
- Assert `halt` at `phase`=0 with P=4: the period completes through `phase`=3, `halted`=1 on the next cycle, and both pulses are 0. Deassert `halt`: `slow_pulse`=1 one cycle later.
- While halted with P=3, pulse `step` once: exactly one `slow_pulse` and one `end_pulse` over 3 cycles, then `halted`=1 again. A `step` with `halt` low goes straight to RUN.
- Drop `nrst` at `phase`=2 with a load pending: outputs immediately return to reset values, and the pending value is never applied.
